job_manager_mc: RTL and testbench

- Multi-channel successor of the single-channel descriptor job manager.
- Queues host-submitted process jobs and fetches descriptor blocks over an AXI read master, one burst in flight.
- Follows descriptor chains through the next-pointer in the last beat.
- Validates beats and steers them into one of NUM_CH per-channel descriptor FIFOs; each consumer engine pulls from its own FIFO.
- Reserves FIFO credit before issuing a read, so channel FIFOs never overflow.

---
 rtl/job_manager_mc.sv | 197 +++++++++++++++++++
 tb/tb_job_manager_mc.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/job_manager_mc.sv
// job_manager_mc: queues descriptor jobs, fetches descriptor bursts over AXI and steers them into per-channel FIFOs.
// Define JM_MAGIC_CHECK_EN to drop beats with a bad magic and report them as a burst error.
module job_manager_mc #(
    parameter int NUM_CH = 4,
    parameter int CH_WIDTH = 2,
    parameter int DATA_WIDTH = 1024,
    parameter int ADDR_WIDTH = 64,
    parameter int ID_WIDTH = 1,
    parameter int RD_ID = 0,
    parameter int PASID_WIDTH = 9,
    parameter int PQ_DEPTH = 16,
    parameter int DSC_DEPTH = 32,
    parameter logic [15:0] MAGIC = 16'h20F8
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [CH_WIDTH+5+PASID_WIDTH+ADDR_WIDTH-1:0] process_info_i,
    input  logic                                         process_valid_i,
    output logic                                         process_ready_o,
    input  logic [NUM_CH-1:0]                            dsc_pull_i,
    output logic [NUM_CH*DATA_WIDTH-1:0]                 dsc_data_o,
    output logic [NUM_CH-1:0]                            dsc_ready_o,
    output logic                                         err_valid_o,
    output logic [CH_WIDTH-1:0]                          err_ch_o,
    output logic [PASID_WIDTH-1:0]                       err_pasid_o,
    output logic                                         busy_o,
    output logic [ID_WIDTH-1:0]                          m_axi_arid,
    output logic [ADDR_WIDTH-1:0]                        m_axi_araddr,
    output logic [7:0]                                   m_axi_arlen,
    output logic [2:0]                                   m_axi_arsize,
    output logic [1:0]                                   m_axi_arburst,
    output logic [PASID_WIDTH-1:0]                       m_axi_aruser,
    output logic [3:0]                                   m_axi_arcache,
    output logic                                         m_axi_arlock,
    output logic [2:0]                                   m_axi_arprot,
    output logic [3:0]                                   m_axi_arqos,
    output logic [3:0]                                   m_axi_arregion,
    output logic                                         m_axi_arvalid,
    input  logic                                         m_axi_arready,
    input  logic [ID_WIDTH-1:0]                          m_axi_rid,
    input  logic [DATA_WIDTH-1:0]                        m_axi_rdata,
    input  logic [1:0]                                   m_axi_rresp,
    input  logic                                         m_axi_rlast,
    input  logic                                         m_axi_rvalid,
    output logic                                         m_axi_rready
);
    localparam int JW = CH_WIDTH + 5 + PASID_WIDTH + ADDR_WIDTH;
    localparam int QW = $clog2(PQ_DEPTH);
    localparam int PW = $clog2(DSC_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, AR, RD} state_t;

    state_t state_q, state_d;
    logic [JW-1:0] pq_mem [PQ_DEPTH];
    logic [QW-1:0] pq_wr_q, pq_wr_d, pq_rd_q, pq_rd_d;
    logic [QW:0] pq_cnt_q, pq_cnt_d;
    logic [CH_WIDTH-1:0] ch_q, ch_d, err_ch_q, err_ch_d;
    logic [4:0] len_q, len_d;
    logic [PASID_WIDTH-1:0] pasid_q, pasid_d, err_pasid_q, err_pasid_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic err_q, err_d, err_valid_q, err_valid_d;
    logic [DATA_WIDTH-1:0] dsc_mem [NUM_CH][DSC_DEPTH];
    logic [PW-1:0] wr_q [NUM_CH], wr_d [NUM_CH], rd_q [NUM_CH], rd_d [NUM_CH];
    logic [CW-1:0] cnt_q [NUM_CH], cnt_d [NUM_CH];
    logic [NUM_CH-1:0] wen, ren;
    logic [JW-1:0] head, pq_in;
    logic [CH_WIDTH-1:0] head_ch;
    logic [4:0] head_len;
    logic [CW-1:0] free;
    logic [63:0] next_ptr;
    logic [DATA_WIDTH-1:0] push_word;
    logic beat, last, bad, push, chain_push, pq_push;

    assign head = pq_mem[pq_rd_q];
    assign head_ch = head[JW-1 -: CH_WIDTH];
    assign head_len = head[ADDR_WIDTH+PASID_WIDTH +: 5];
    assign beat = state_q == RD && m_axi_rvalid && m_axi_rid == ID_WIDTH'(RD_ID);
    assign last = beat && m_axi_rlast;
`ifdef JM_MAGIC_CHECK_EN
    assign bad = m_axi_rresp != 2'b00 || m_axi_rdata[31:16] != MAGIC;
`else
    assign bad = m_axi_rresp != 2'b00;
`endif
    assign push = beat && !err_q && !bad && m_axi_rdata[0];
    assign next_ptr = m_axi_rdata[DATA_WIDTH-1 -: 64];
    assign chain_push = last && !err_q && !bad && next_ptr != 64'd0;
    assign push_word = {32'(pasid_q), m_axi_rdata[DATA_WIDTH-33:0]};
    assign process_ready_o = pq_cnt_q != (QW+1)'(PQ_DEPTH) && !chain_push;
    assign pq_push = chain_push || (process_valid_i && process_ready_o);
    // A chained job inherits channel and PASID; its length comes from the last beat.
    assign pq_in = chain_push ? {ch_q, m_axi_rdata[12:8], pasid_q, ADDR_WIDTH'(next_ptr)} : process_info_i;

    assign m_axi_arid = ID_WIDTH'(RD_ID);
    assign m_axi_araddr = addr_q;
    assign m_axi_arlen = {3'b0, len_q};
    assign m_axi_arsize = 3'($clog2(DATA_WIDTH / 8));
    assign m_axi_arburst = 2'b01;
    assign m_axi_aruser = pasid_q;
    assign m_axi_arcache = 4'd3;
    assign m_axi_arlock = 1'b0;
    assign m_axi_arprot = 3'd0;
    assign m_axi_arqos = 4'd0;
    assign m_axi_arregion = 4'd0;
    assign m_axi_arvalid = state_q == AR;
    assign m_axi_rready = 1'b1;
    assign err_valid_o = err_valid_q;
    assign err_ch_o = err_ch_q;
    assign err_pasid_o = err_pasid_q;
    assign busy_o = pq_cnt_q != '0 || state_q != IDLE;

    always_comb begin
        pq_wr_d = pq_wr_q + QW'(pq_push);
        pq_rd_d = pq_rd_q + QW'(last);
        pq_cnt_d = pq_cnt_q + (QW+1)'(pq_push) - (QW+1)'(last);
        state_d = state_q;
        ch_d = ch_q;
        len_d = len_q;
        pasid_d = pasid_q;
        addr_d = addr_q;
        // Credit is reserved for the whole burst before the read is issued.
        free = CW'(DSC_DEPTH) - cnt_q[head_ch];
        if (state_q == IDLE) begin
            ch_d = head_ch;
            len_d = head_len;
            pasid_d = head[ADDR_WIDTH +: PASID_WIDTH];
            addr_d = head[ADDR_WIDTH-1:0];
            state_d = pq_cnt_q != '0 && free >= CW'(head_len) + CW'(1) ? AR : IDLE;
        end
        if (state_q == AR && m_axi_arready) state_d = RD;
        if (last) state_d = IDLE;
        err_d = state_q == RD && !last && (err_q || (beat && bad));
        err_valid_d = last && (err_q || bad);
        err_ch_d = ch_q;
        err_pasid_d = pasid_q;
    end

    always_comb begin
        dsc_data_o = '0;
        dsc_ready_o = '0;
        wen = '0;
        ren = '0;
        wr_d = wr_q;
        rd_d = rd_q;
        cnt_d = cnt_q;
        for (int c = 0; c < NUM_CH; c++) begin
            wen[c] = push && ch_q == CH_WIDTH'(c);
            ren[c] = dsc_pull_i[c] && cnt_q[c] != '0;
            wr_d[c] = wr_q[c] + PW'(wen[c]);
            rd_d[c] = rd_q[c] + PW'(ren[c]);
            cnt_d[c] = cnt_q[c] + CW'(wen[c]) - CW'(ren[c]);
            dsc_ready_o[c] = cnt_q[c] != '0;
            dsc_data_o[c*DATA_WIDTH +: DATA_WIDTH] = dsc_mem[c][rd_q[c]];
        end
    end

    always_ff @(posedge clk) begin
        if (pq_push) pq_mem[pq_wr_q] <= pq_in;
        if (push) dsc_mem[ch_q][wr_q[ch_q]] <= push_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pq_wr_q <= '0;
            pq_rd_q <= '0;
            pq_cnt_q <= '0;
            ch_q <= '0;
            len_q <= '0;
            pasid_q <= '0;
            addr_q <= '0;
            err_q <= 1'b0;
            err_valid_q <= 1'b0;
            err_ch_q <= '0;
            err_pasid_q <= '0;
            wr_q <= '{default: '0};
            rd_q <= '{default: '0};
            cnt_q <= '{default: '0};
        end else begin
            state_q <= state_d;
            pq_wr_q <= pq_wr_d;
            pq_rd_q <= pq_rd_d;
            pq_cnt_q <= pq_cnt_d;
            ch_q <= ch_d;
            len_q <= len_d;
            pasid_q <= pasid_d;
            addr_q <= addr_d;
            err_q <= err_d;
            err_valid_q <= err_valid_d;
            err_ch_q <= err_ch_d;
            err_pasid_q <= err_pasid_d;
            wr_q <= wr_d;
            rd_q <= rd_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: tb/tb_job_manager_mc.sv
// tb_job_manager_mc: directed stimulus with a queue-based scoreboard for job_manager_mc.
module tb_job_manager_mc;
    localparam int NUM_CH = 4;
    localparam int CHW = 2;
    localparam int DW = 1024;
    localparam int AW = 64;
    localparam int PW = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [CHW+5+PW+AW-1:0] process_info_i;
    logic process_valid_i, process_ready_o;
    logic [NUM_CH-1:0] dsc_pull_i, dsc_ready_o;
    logic [NUM_CH*DW-1:0] dsc_data_o;
    logic err_valid_o, busy_o;
    logic [CHW-1:0] err_ch_o;
    logic [PW-1:0] err_pasid_o;
    logic [0:0] m_axi_arid, m_axi_rid;
    logic [AW-1:0] m_axi_araddr;
    logic [7:0] m_axi_arlen;
    logic [2:0] m_axi_arsize, m_axi_arprot;
    logic [1:0] m_axi_arburst, m_axi_rresp;
    logic [PW-1:0] m_axi_aruser;
    logic [3:0] m_axi_arcache, m_axi_arqos, m_axi_arregion;
    logic m_axi_arlock, m_axi_arvalid, m_axi_arready;
    logic [DW-1:0] m_axi_rdata;
    logic m_axi_rlast, m_axi_rvalid, m_axi_rready;

    job_manager_mc dut (
        .clk(clk), .rst(rst),
        .process_info_i(process_info_i), .process_valid_i(process_valid_i), .process_ready_o(process_ready_o),
        .dsc_pull_i(dsc_pull_i), .dsc_data_o(dsc_data_o), .dsc_ready_o(dsc_ready_o),
        .err_valid_o(err_valid_o), .err_ch_o(err_ch_o), .err_pasid_o(err_pasid_o), .busy_o(busy_o),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_aruser(m_axi_aruser),
        .m_axi_arcache(m_axi_arcache), .m_axi_arlock(m_axi_arlock), .m_axi_arprot(m_axi_arprot),
        .m_axi_arqos(m_axi_arqos), .m_axi_arregion(m_axi_arregion), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata),
        .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready)
    );

    typedef struct packed {logic [CHW-1:0] ch; logic [DW-1:0] d;} dsc_t;
    typedef struct packed {logic [AW-1:0] addr; logic [7:0] len; logic [PW-1:0] pasid;} ar_t;
    typedef struct packed {logic [CHW-1:0] ch; logic [PW-1:0] pasid;} err_t;

    dsc_t exp_dsc[$];
    ar_t exp_ar[$];
    err_t exp_err[$];
    dsc_t ed;
    ar_t ea;
    err_t ee;
    logic [DW-1:0] got_d;
    int n_vec = 0;
    int n_err = 0;
    logic [DW-1:0] bd[64];
    logic [1:0] br[64];
    logic chk_chain = 1'b0;
    logic stall;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: event seen with nothing expected or timed out", name);
    endtask

    function automatic logic [DW-1:0] mk_beat(input logic [31:0] tag, input logic [63:0] nxt,
                                              input logic [4:0] clen, input logic [15:0] mg);
        logic [DW-1:0] d;
        d = '0;
        d[DW-1 -: 64] = nxt;
        d[DW-65 -: 32] = ~tag;
        d[63:32] = tag;
        d[31:16] = mg;
        d[12:8] = clen;
        d[0] = 1'b1;
        return d;
    endfunction

    task automatic prep(input int n, input int tag, input logic [63:0] nxt, input logic [4:0] clen);
        for (int i = 0; i < n; i++) begin
            bd[i] = mk_beat(32'(tag + i), i == n - 1 ? nxt : 64'd0, i == n - 1 ? clen : 5'd0, 16'h20F8);
            br[i] = 2'b00;
        end
    endtask

    task automatic expect_words(input logic [CHW-1:0] ch, input logic [PW-1:0] pasid, input int i0, input int i1);
        dsc_t e;
        for (int i = i0; i <= i1; i++) begin
            e.ch = ch;
            e.d = {32'(pasid), bd[i][DW-33:0]};
            exp_dsc.push_back(e);
        end
    endtask

    task automatic push_ar(input logic [AW-1:0] addr, input logic [4:0] len, input logic [PW-1:0] pasid);
        ar_t a;
        a.addr = addr;
        a.len = {3'b0, len};
        a.pasid = pasid;
        exp_ar.push_back(a);
    endtask

    task automatic push_err(input logic [CHW-1:0] ch, input logic [PW-1:0] pasid);
        err_t e;
        e.ch = ch;
        e.pasid = pasid;
        exp_err.push_back(e);
    endtask

    task automatic submit(input logic [CHW-1:0] ch, input logic [4:0] len, input logic [PW-1:0] pasid,
                          input logic [AW-1:0] addr);
        int t;
        t = 0;
        push_ar(addr, len, pasid);
        process_info_i = {ch, len, pasid, addr};
        process_valid_i = 1'b1;
        @(negedge clk);
        while (!process_ready_o && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!process_ready_o) fail("submit_timeout");
        @(posedge clk);
        #1 process_valid_i = 1'b0;
    endtask

    task automatic wait_ar(input int ar_delay);
        int t, k;
        t = 0;
        k = 0;
        m_axi_arready = 1'b0;
        forever begin
            @(negedge clk);
            if (m_axi_arvalid && m_axi_arready) break;
            if (++t > 300) begin
                fail("ar_timeout");
                return;
            end
            @(posedge clk);
            #1;
            if (m_axi_arvalid) begin
                k++;
                m_axi_arready = k > ar_delay;
            end
        end
        @(posedge clk);
        #1 m_axi_arready = 1'b0;
    endtask

    task automatic drive_beats(input int n);
        for (int i = 0; i < n; i++) begin
            m_axi_rvalid = 1'b1;
            m_axi_rdata = bd[i];
            m_axi_rresp = br[i];
            m_axi_rlast = i == n - 1;
            if (i == n - 1 && chk_chain) begin
                @(negedge clk);
                check("chain_ready_low", process_ready_o, 0);
            end
            @(posedge clk);
            #1;
        end
        m_axi_rvalid = 1'b0;
        m_axi_rlast = 1'b0;
    endtask

    task automatic pull(input int n);
        int t, sel;
        for (int i = 0; i < n; i++) begin
            t = 0;
            while (dsc_ready_o == '0 && t < 50) begin
                @(posedge clk);
                #1 t++;
            end
            if (dsc_ready_o == '0) begin
                fail("pull_timeout");
                return;
            end
            sel = 0;
            for (int c = NUM_CH - 1; c >= 0; c--) if (dsc_ready_o[c]) sel = c;
            dsc_pull_i = '0;
            dsc_pull_i[sel] = 1'b1;
            @(posedge clk);
            #1 dsc_pull_i = '0;
        end
    endtask

    // Scoreboard monitor: pops an expectation whenever the DUT presents an AR, a FIFO word or an error.
    always @(negedge clk) begin
        if (!rst) begin
            if (m_axi_arvalid && m_axi_arready) begin
                if (exp_ar.size() == 0) fail("ar_unexpected");
                else begin
                    ea = exp_ar.pop_front();
                    check("ar_addr", m_axi_araddr, ea.addr);
                    check("ar_len", m_axi_arlen, ea.len);
                    check("ar_user", m_axi_aruser, ea.pasid);
                    check("ar_const", {m_axi_arid, m_axi_arsize, m_axi_arburst, m_axi_arcache, m_axi_arlock,
                          m_axi_arprot, m_axi_arqos, m_axi_arregion}, {1'b0, 3'd7, 2'b01, 4'd3, 1'b0, 3'd0, 4'd0, 4'd0});
                end
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (dsc_pull_i[c] && dsc_ready_o[c]) begin
                    if (exp_dsc.size() == 0) fail("dsc_unexpected");
                    else begin
                        ed = exp_dsc.pop_front();
                        got_d = dsc_data_o[c*DW +: DW];
                        n_vec++;
                        if (ed.ch != CHW'(c) || got_d !== ed.d) begin
                            n_err++;
                            $display("FAIL dsc_word: got ch%0d top %0h low %0h expected ch%0d top %0h low %0h",
                                     c, got_d[DW-1 -: 64], got_d[95:0], ed.ch, ed.d[DW-1 -: 64], ed.d[95:0]);
                        end
                    end
                end
            end
            if (err_valid_o) begin
                if (exp_err.size() == 0) fail("err_unexpected");
                else begin
                    ee = exp_err.pop_front();
                    check("err_ch", err_ch_o, ee.ch);
                    check("err_pasid", err_pasid_o, ee.pasid);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        process_info_i = '0;
        process_valid_i = 1'b0;
        dsc_pull_i = '0;
        m_axi_arready = 1'b0;
        m_axi_rid = 1'b0;
        m_axi_rdata = '0;
        m_axi_rresp = 2'b00;
        m_axi_rlast = 1'b0;
        m_axi_rvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_arvalid", m_axi_arvalid, 0);
        check("rst_busy", busy_o, 0);
        check("rst_dsc_ready", dsc_ready_o, 0);
        check("rst_err", err_valid_o, 0);
        check("rst_proc_ready", process_ready_o, 1);
        check("rready", m_axi_rready, 1);
        @(posedge clk);
        #1;
        // Single job with a delayed arready.
        submit(2'd2, 5'd3, 9'h05A, 64'h1000);
        prep(4, 'h100, 64'd0, 5'd0);
        expect_words(2'd2, 9'h05A, 0, 3);
        wait_ar(2);
        drive_beats(4);
        @(negedge clk);
        check("single_busy", busy_o, 0);
        check("single_ready", dsc_ready_o, 4'b0100);
        @(posedge clk);
        #1 pull(4);
        check("single_drained", dsc_ready_o, 0);
        // Chain follow from the last beat.
        submit(2'd3, 5'd0, 9'h011, 64'h3000);
        push_ar(64'h2000, 5'd1, 9'h011);
        prep(1, 'h200, 64'h2000, 5'd1);
        expect_words(2'd3, 9'h011, 0, 0);
        chk_chain = 1'b1;
        wait_ar(0);
        drive_beats(1);
        chk_chain = 1'b0;
        prep(2, 'h300, 64'd0, 5'd0);
        expect_words(2'd3, 9'h011, 0, 1);
        wait_ar(0);
        drive_beats(2);
        pull(3);
        // Credit stall: 30 words in FIFO1 block a 4-beat job until 2 are pulled.
        submit(2'd1, 5'd15, 9'h0A1, 64'h10000);
        submit(2'd1, 5'd13, 9'h0A2, 64'h20000);
        submit(2'd1, 5'd3, 9'h0A3, 64'h30000);
        prep(16, 'h400, 64'd0, 5'd0);
        expect_words(2'd1, 9'h0A1, 0, 15);
        wait_ar(0);
        drive_beats(16);
        prep(14, 'h500, 64'd0, 5'd0);
        expect_words(2'd1, 9'h0A2, 0, 13);
        wait_ar(0);
        drive_beats(14);
        stall = 1'b0;
        repeat (10) begin
            @(negedge clk);
            stall |= m_axi_arvalid;
        end
        check("credit_stall", stall, 0);
        check("credit_busy", busy_o, 1);
        check("credit_ready", dsc_ready_o, 4'b0010);
        @(posedge clk);
        #1 pull(2);
        @(negedge clk);
        @(negedge clk);
        check("credit_issue", m_axi_arvalid, 1);
        prep(4, 'h600, 64'd0, 5'd0);
        expect_words(2'd1, 9'h0A3, 0, 3);
        wait_ar(0);
        drive_beats(4);
        pull(32);
        // Response error on beat 1: only beat 0 lands, chain pointer ignored.
        submit(2'd0, 5'd3, 9'h033, 64'h4000);
        prep(4, 'h700, 64'h5000, 5'd2);
        br[1] = 2'b10;
        expect_words(2'd0, 9'h033, 0, 0);
        push_err(2'd0, 9'h033);
        wait_ar(0);
        drive_beats(4);
        stall = 1'b0;
        repeat (5) begin
            @(negedge clk);
            stall |= m_axi_arvalid;
        end
        check("err_no_chain", stall, 0);
        check("err_busy", busy_o, 0);
        check("err_ready", dsc_ready_o, 4'b0001);
        @(posedge clk);
        #1 pull(1);
        // Bad magic on beat 0.
        submit(2'd2, 5'd1, 9'h044, 64'h7000);
        prep(2, 'h800, 64'd0, 5'd0);
        bd[0][31:16] = 16'h1234;
`ifdef JM_MAGIC_CHECK_EN
        push_err(2'd2, 9'h044);
`else
        expect_words(2'd2, 9'h044, 0, 1);
`endif
        wait_ar(0);
        drive_beats(2);
`ifndef JM_MAGIC_CHECK_EN
        pull(2);
`endif
        @(negedge clk);
        check("magic_drained", dsc_ready_o, 0);
        @(posedge clk);
        #1;
        // Reset mid-burst, then a stray last beat.
        submit(2'd1, 5'd3, 9'h055, 64'h6000);
        prep(4, 'h900, 64'd0, 5'd0);
        wait_ar(0);
        m_axi_rvalid = 1'b1;
        m_axi_rdata = bd[0];
        m_axi_rresp = 2'b00;
        m_axi_rlast = 1'b0;
        @(posedge clk);
        #1 m_axi_rvalid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        m_axi_rvalid = 1'b1;
        m_axi_rdata = mk_beat(32'h999, 64'h8000, 5'd1, 16'h20F8);
        m_axi_rlast = 1'b1;
        @(posedge clk);
        #1 m_axi_rvalid = 1'b0;
        m_axi_rlast = 1'b0;
        @(negedge clk);
        check("rstmid_ready", dsc_ready_o, 0);
        check("rstmid_arvalid", m_axi_arvalid, 0);
        check("rstmid_busy", busy_o, 0);
        repeat (3) @(negedge clk);
        check("rstmid_idle", {m_axi_arvalid, busy_o, dsc_ready_o}, 0);
        check("sb_ar_left", exp_ar.size(), 0);
        check("sb_dsc_left", exp_dsc.size(), 0);
        check("sb_err_left", exp_err.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
